instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the control decoder: accepts field-level instruction requests
//  (op class + register/immediate fields) over a valid/ready handshake and
//  emits 32-bit MIPS machine words. Words are written sequentially into
//  instruction memory through a write/ack port.
//  Sits between the program loader / self-test sequencer and instruction memory.
// PARAMETERS
//  FIFO_DEPTH  4   request buffer entries (power of 2, >=2)
//  CNT_W       16  width of emitted-word counter count_o
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   reset, asynchronous, active-low
//  req_valid_i  in   1   request valid
//  req_ready_o  out  1   request ready (FIFO not full)
//  req_op_i     in   3   0 R-type, 1 addi, 2 sltiu, 3 beq, 4 lui, 5 ori, 6 bne, 7 illegal
//  req_rs_i     in   5   rs field
//  req_rt_i     in   5   rt field
//  req_rd_i     in   5   rd field (R-type only)
//  req_shamt_i  in   5   shamt field (R-type only)
//  req_funct_i  in   6   funct field (R-type only)
//  req_imm_i    in   16  immediate / branch offset (I-type only)
//  base_load_i  in   1   load write address from base_addr_i
//  base_addr_i  in   32  start byte address
//  mem_we_o     out  1   memory write strobe, held until ack
//  mem_addr_o   out  32  byte write address
//  mem_data_o   out  32  encoded instruction word
//  mem_ack_i    in   1   memory accepted current write
//  err_o        out  1   sticky: illegal op received
//  count_o      out  CNT_W  words written since reset (wraps)
// BEHAVIOUR
//  - Reset: req_ready_o=1 once rst_i deasserts (0 while rst_i low), mem_we_o=0,
//    mem_addr_o=0, mem_data_o=0, err_o=0, count_o=0. FIFO is empty; FSM is in IDLE.
//  - Handshake: a transfer occurs on an edge where req_valid_i && req_ready_o.
//    req_ready_o = !full.
//  - Encoding:
//    - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
//    - I-type: {opc, rs, rt, imm}, with opcodes addi 001000, sltiu 001011,
//      beq 000100, lui 001111, ori 001101, bne 000101.
//    - lui forces the rs field to 5'b0.
//    - Encoding happens at push; the FIFO stores 32-bit words plus a branch tag.
//  - op 7: the handshake completes, nothing is queued, and err_o is set. err_o
//    stays set until reset.
//  - FSM states:
//    - IDLE: if FIFO not empty, pop and go to WRITE.
//    - WRITE: mem_we_o=1 and mem_data_o/mem_addr_o held stable. On mem_ack_i:
//      mem_addr_o += 4, count_o += 1, then go to PAD if branch && ENC_NOP_PAD_EN,
//      else go to IDLE.
//    - PAD: writes 32'h0000_0000 with the same ack rule, then goes to IDLE.
//  - Latency: with the FIFO empty and a request accepted at edge N, mem_we_o is
//    high after edge N+1. After an ack, the next queued word is presented after
//    ack edge +1 (one IDLE cycle).
//  - Simultaneous push and pop: allowed. Occupancy is unchanged.
//  - When full: no push; ready is low in that cycle.
//  - base_load_i: honoured only in IDLE with the FIFO empty. Otherwise it is ignored.
//  - mem_addr_o and count_o wrap modulo 2^32 and 2^CNT_W.
//  - Reset mid-write: mem_we_o drops immediately (async). FIFO contents are lost.
// CONFIGURATION
//  ENC_NOP_PAD_EN  defined: every beq/bne word is followed by a NOP (delay slot)
//                  at the next address; count_o includes the NOP.
//                  undefined: no PAD state; branches are written like any other word.
// TESTING
//  - R-type: op0 rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> mem_data_o=0x00221820 @addr 0,
//    then count_o=1.
//  - base_load 0x100; addi rs=0 rt=8 imm=0xFFFF; lui rs=5 rt=9 imm=0x1234
//    -> 0x2008FFFF @0x100, 0x3C091234 @0x104.
//  - Fill FIFO with mem_ack_i=0: 4 pushes accepted (plus 1 in WRITE), ready drops;
//    releasing ack drains the words in order.
//  - op7 request -> handshake completes, err_o=1, no write; next valid request
//    still written.
//  - beq rs=1 rt=2 imm=3 -> 0x10220003. With ENC_NOP_PAD_EN, 0x00000000 follows at
//    +4 and count_o=2.
//  - Assert rst_i low during WRITE -> mem_we_o=0 same cycle; after release,
//    addr=0 and count_o=0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS field-to-word encoder with request FIFO and memory write port; optional ENC_NOP_PAD_EN
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [4:0]       req_rs_i,
  input  logic [4:0]       req_rt_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_shamt_i,
  input  logic [5:0]       req_funct_i,
  input  logic [15:0]      req_imm_i,
  input  logic             base_load_i,
  input  logic [31:0]      base_addr_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic             mem_ack_i,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

`ifdef ENC_NOP_PAD_EN
  // Entries carry a branch tag so the write side knows to follow with a NOP.
  localparam int EW = 33;
  typedef enum logic [1:0] {IDLE, WRITE, PAD} state_t;
`else
  localparam int EW = 32;
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t state, next_state;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty;
  logic          accept, push, pop, wr_done;
  logic [31:0]   enc_word;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
`ifdef ENC_NOP_PAD_EN
  logic          is_branch;
  logic          cur_branch;
`endif

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign req_ready_o = rst_i && !full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && (req_op_i != 3'd7);
  assign pop         = (state == IDLE) && !empty;
  assign wr_done     = mem_we_o && mem_ack_i;
  assign head_entry  = fifo_mem[rd_ptr[AW-1:0]];

  // Field-to-word encoding, done at push so the FIFO holds finished words.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (req_op_i)
      3'd0: enc_word = {6'b000000, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
      3'd1: enc_word = {6'b001000, req_rs_i, req_rt_i, req_imm_i};
      3'd2: enc_word = {6'b001011, req_rs_i, req_rt_i, req_imm_i};
      3'd3: enc_word = {6'b000100, req_rs_i, req_rt_i, req_imm_i};
      3'd4: enc_word = {6'b001111, 5'b00000, req_rt_i, req_imm_i};
      3'd5: enc_word = {6'b001101, req_rs_i, req_rt_i, req_imm_i};
      3'd6: enc_word = {6'b000101, req_rs_i, req_rt_i, req_imm_i};
      default: enc_word = 32'h0000_0000;
    endcase
  end

`ifdef ENC_NOP_PAD_EN
  assign is_branch  = (req_op_i == 3'd3) || (req_op_i == 3'd6);
  assign push_entry = {is_branch, enc_word};
`else
  assign push_entry = enc_word;
`endif

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and write strobe: strobe is held in WRITE/PAD until acked.
  always_comb begin
    next_state = state;
    mem_we_o   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        mem_we_o = 1'b1;
        if (mem_ack_i) begin
`ifdef ENC_NOP_PAD_EN
          next_state = cur_branch ? PAD : IDLE;
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef ENC_NOP_PAD_EN
      PAD: begin
        mem_we_o = 1'b1;
        if (mem_ack_i) begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Pointers, write address/data, counter and sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_addr_o <= 32'h0000_0000;
      mem_data_o <= 32'h0000_0000;
      count_o    <= '0;
      err_o      <= 1'b0;
`ifdef ENC_NOP_PAD_EN
      cur_branch <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (accept && (req_op_i == 3'd7)) begin
        err_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        mem_data_o <= head_entry[31:0];
`ifdef ENC_NOP_PAD_EN
        cur_branch <= head_entry[32];
`endif
      end
      if (wr_done) begin
        mem_addr_o <= mem_addr_o + 32'd4;
        count_o    <= count_o + CNT_ONE;
`ifdef ENC_NOP_PAD_EN
        // The delay-slot NOP is written next, so clear the data now.
        if ((state == WRITE) && cur_branch) begin
          mem_data_o <= 32'h0000_0000;
        end
`endif
      end
      // A new base only takes effect when nothing is queued or in flight.
      if ((state == IDLE) && empty && base_load_i) begin
        mem_addr_o <= base_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [4:0]  req_rs_i;
  logic [4:0]  req_rt_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_shamt_i;
  logic [5:0]  req_funct_i;
  logic [15:0] req_imm_i;
  logic        base_load_i;
  logic [31:0] base_addr_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic        err_o;
  logic [15:0] count_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  instr_encoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_rs_i(req_rs_i), .req_rt_i(req_rt_i),
    .req_rd_i(req_rd_i), .req_shamt_i(req_shamt_i), .req_funct_i(req_funct_i),
    .req_imm_i(req_imm_i), .base_load_i(base_load_i), .base_addr_i(base_addr_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .err_o(err_o), .count_o(count_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every acknowledged write is matched against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_i && mem_we_o && mem_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 mem_addr_o, mem_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check32("wr_addr", mem_addr_o, mon_e.addr);
        check32("wr_data", mem_data_o, mon_e.data);
      end
    end
  end

  // Offer one request until accepted; queue its expected write on acceptance.
  task automatic push(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [31:0] ea, input logic [31:0] ed);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    req_op_i = op; req_rs_i = rs; req_rt_i = rt; req_rd_i = rd;
    req_shamt_i = sh; req_funct_i = fn; req_imm_i = imm;
    req_valid_i = 1'b1;
    while (!acc && n < 50) begin
      acc = req_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready=0 for 50 cycles expected acceptance");
    end else if (op != 3'd7) begin
      exp_q.push_back(exp_t'({ea, ed}));
    end
  endtask

  // Wait until all expected writes are seen and the write port is idle.
  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while ((exp_q.size() != 0 || mem_we_o) && n < 200);
    if (exp_q.size() != 0 || mem_we_o) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending writes expected 0", exp_q.size());
    end
  endtask

  task automatic load_base(input logic [31:0] a);
    base_addr_i = a;
    base_load_i = 1'b1;
    @(posedge clk_i);
    #1;
    base_load_i = 1'b0;
  endtask

  // Directed stimulus sequence.
  initial begin
    rst_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_rs_i = '0; req_rt_i = '0;
    req_rd_i = '0; req_shamt_i = '0; req_funct_i = '0; req_imm_i = '0;
    base_load_i = 1'b0; base_addr_i = '0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check32("ready_in_reset", req_ready_o, 0);
    rst_i = 1'b1;
    #1;
    check32("rst_ready", req_ready_o, 1);
    check32("rst_we", mem_we_o, 0);
    check32("rst_addr", mem_addr_o, 0);
    check32("rst_data", mem_data_o, 0);
    check32("rst_err", err_o, 0);
    check32("rst_count", count_o, 0);
    @(posedge clk_i);
    #1;

    // R-type and first-write latency
    mem_ack_i = 1'b1;
    push(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h0, 32'h0022_1820);
    check32("lat_we_low", mem_we_o, 0);
    @(posedge clk_i);
    #1;
    check32("lat_we_high", mem_we_o, 1);
    drain();
    check32("count_rtype", count_o, 1);

    // base load then addi / lui (lui drops rs)
    load_base(32'h100);
    check32("base_loaded", mem_addr_o, 32'h100);
    push(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 32'h100, 32'h2008_FFFF);
    push(3'd4, 5'd5, 5'd9, 5'd0, 5'd0, 6'h0, 16'h1234, 32'h104, 32'h3C09_1234);
    drain();
    check32("count_base", count_o, 3);

    // fill with ack held low: 1 in WRITE plus 4 buffered
    mem_ack_i = 1'b0;
    push(3'd2, 5'd3,  5'd4,  5'd0, 5'd0, 6'h0,  16'h0010, 32'h108, 32'h2C64_0010);
    push(3'd5, 5'd5,  5'd6,  5'd0, 5'd0, 6'h0,  16'h00FF, 32'h10C, 32'h34A6_00FF);
    push(3'd0, 5'd7,  5'd8,  5'd9, 5'd2, 6'h00, 16'h0,    32'h110, 32'h00E8_4880);
    push(3'd1, 5'd31, 5'd31, 5'd0, 5'd0, 6'h0,  16'h8000, 32'h114, 32'h23FF_8000);
    push(3'd4, 5'd31, 5'd1,  5'd0, 5'd0, 6'h0,  16'hABCD, 32'h118, 32'h3C01_ABCD);
    check32("ready_full", req_ready_o, 0);
    load_base(32'h500);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    check32("ready_full_hold", req_ready_o, 0);
    check32("we_held", mem_we_o, 1);
    check32("addr_held", mem_addr_o, 32'h108);
    check32("data_held", mem_data_o, 32'h2C64_0010);
    mem_ack_i = 1'b1;
    drain();
    check32("count_fill", count_o, 8);

    // illegal op: accepted, flagged, not written
    push(3'd7, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 32'h0, 32'h0);
    check32("err_set", err_o, 1);
    @(posedge clk_i);
    #1;
    check32("illegal_no_write", mem_we_o, 0);
    push(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22, 16'h0, 32'h11C, 32'h0022_1822);
    drain();
    check32("count_after_illegal", count_o, 9);
    check32("err_sticky", err_o, 1);

    // branch, with delay-slot NOP when padding is built in
    push(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 32'h120, 32'h1022_0003);
`ifdef ENC_NOP_PAD_EN
    exp_q.push_back(exp_t'({32'h124, 32'h0}));
`endif
    drain();
`ifdef ENC_NOP_PAD_EN
    check32("count_beq", count_o, 11);
`else
    check32("count_beq", count_o, 10);
`endif

    // address wrap at 2^32
    load_base(32'hFFFF_FFFC);
    push(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0001, 32'hFFFF_FFFC, 32'h3400_0001);
    push(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0002, 32'h0,         32'h2001_0002);
    drain();
    check32("addr_wrap", mem_addr_o, 32'h4);
`ifdef ENC_NOP_PAD_EN
    check32("count_wrap", count_o, 13);
`else
    check32("count_wrap", count_o, 12);
`endif

    // reset in the middle of a write
    mem_ack_i = 1'b0;
    push(3'd5, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'h00FF, 32'h8, 32'h34A6_00FF);
    @(posedge clk_i);
    #1;
    check32("we_before_reset", mem_we_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check32("we_async_drop", mem_we_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    check32("ready_mid_reset", req_ready_o, 0);
    rst_i = 1'b1;
    #1;
    check32("rst2_addr", mem_addr_o, 0);
    check32("rst2_count", count_o, 0);
    check32("rst2_err", err_o, 0);
    check32("rst2_ready", req_ready_o, 1);
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    push(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h0, 32'h0022_1820);
    drain();
    check32("count_after_reset", count_o, 1);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
